pio_rmw_arbiter: RTL

Round-robin arbiter that shares one Avalon-MM 8-bit output PIO slave between NUM_REQ requesters. Each requester submits a bit mask and a value. The block performs an atomic read-modify-write on PIO data register 0, so requesters can own disjoint bits of out_port without clobbering each other. It sits between internal control logic (LED/status drivers) and the PIO slave port. It is the only master of that slave.

---
 rtl/pio_rmw_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/pio_rmw_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pio_rmw_pkg.sv
// Shared constants and helpers for the PIO read-modify-write arbiter.
// State encodings are plain localparams so they drop into older flows unchanged.
package pio_rmw_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Bits selected by mask come from data, all others keep the value read back.
  function automatic logic [31:0] merge(input logic [31:0] rd,
                                        input logic [31:0] mask,
                                        input logic [31:0] data);
    return (rd & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after
// index 'start', wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   idx_wide;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx_wide  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_wide = {1'b0, start} + (IDX_W+1)'(k);
      if (idx_wide >= (IDX_W+1)'(NUM_REQ)) begin
        idx_wide = idx_wide - (IDX_W+1)'(NUM_REQ);
      end
      idx = idx_wide[IDX_W-1:0];
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pio_rmw_arbiter.sv
// Shares one Avalon-MM output PIO between NUM_REQ requesters, performing an
// atomic read-modify-write of data register 0 on behalf of the round-robin winner.
module pio_rmw_arbiter
  import pio_rmw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_mask,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [1:0]                   avm_address,
  output logic                         avm_chipselect,
  output logic                         avm_write_n,
  output logic [31:0]                  avm_writedata,
  input  logic [31:0]                  avm_readdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               ptr_valid_q, ptr_valid_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [DATA_W-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               cs_q, cs_d;
  logic               wn_q, wn_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [DATA_W-1:0]  mask_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [DATA_W-1:0]  win_mask;
  logic [DATA_W-1:0]  win_data;
  logic [31:0]        rd_ext;

  logic [IDX_W-1:0]   arb_start;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign mask_arr[gi] = req_mask[gi*DATA_W +: DATA_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
    if (DATA_W < 32) begin : g_rd_upper
      logic unused_rd_upper;
      assign unused_rd_upper = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  assign win_mask = mask_arr[arb_idx];
  assign win_data = data_arr[arb_idx];
  assign rd_ext   = 32'(avm_readdata[DATA_W-1:0]);

  // Search starts one past the last winner; before any grant it starts at 0.
  always_comb begin
    arb_start = '0;
    if (ptr_valid_q) begin
      arb_start = (ptr_q == IDX_W'(NUM_REQ-1)) ? '0 : ptr_q + 1'b1;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req),
    .start     (arb_start),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ptr_valid_d = ptr_valid_q;
    grant_id_d  = grant_id_q;
    grant_oh_d  = grant_oh_q;
    mask_d      = mask_q;
    data_d      = data_q;
    ack_d       = '0;
    cs_d        = cs_q;
    wn_d        = wn_q;
    wdata_d     = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_id_d = arb_idx;
          grant_oh_d = arb_grant;
          mask_d     = win_mask;
          data_d     = win_data;
          cs_d       = 1'b1;
          // A full mask needs nothing from the register, so skip the read.
          if (win_mask == '1) begin
            state_d = ST_WRITE;
            wn_d    = 1'b0;
            wdata_d = 32'(win_data);
          end else begin
            state_d = ST_READ;
            wn_d    = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
        wn_d    = 1'b0;
        wdata_d = merge(rd_ext, 32'(mask_q), 32'(data_q));
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        ack_d   = grant_oh_q;
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        ptr_d       = grant_id_q;
        ptr_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      ptr_valid_q <= 1'b0;
      grant_id_q  <= '0;
      grant_oh_q  <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      ack_q       <= '0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ptr_valid_q <= ptr_valid_d;
      grant_id_q  <= grant_id_d;
      grant_oh_q  <= grant_oh_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      wdata_q     <= wdata_d;
    end
  end

  assign ack            = ack_q;
  assign busy           = (state_q != ST_IDLE);
  assign grant_id       = grant_id_q;
  assign avm_address    = PIO_DATA_ADDR;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wdata_q;

endmodule
